// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage of the 5-stage RISC-V pipeline. It owns the program
//   counter and issues word-aligned fetches over a valid/ready request port,
//   with at most one request outstanding. Responses are captured into the IF/ID
//   pipeline register. A one-entry skid buffer holds a response that arrives
//   while decode is stalled. EX redirects flush IF/ID and drop wrong-path
//   responses.
//
// Ports
//   clk, rst                  clock / asynchronous active-high reset
//   hazardFEEnable            1 = fetch and IF/ID advance, 0 = hold (load-use)
//   ex_redirect(_pc)          taken branch/jump from EX and its target
//   imem_req_valid/addr/ready fetch request handshake
//   imem_resp_valid/data      fetch response (>=1 cycle after acceptance)
//   if_id_valid/pc/pc_plus4/instr  IF/ID pipeline register to decode
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazardFEEnable,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_skid;
  logic        r_if_id_valid;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_pc_plus4;
  logic [31:0] r_if_id_instr;

  logic [31:0] w_pc_plus4;
  logic        w_fast_req;
  logic        w_handshake;
  logic        w_deliver;
  logic [31:0] w_deliver_data;

  // Wraps modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.
  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    // Fast path: the response for pc is consumed this cycle, so the next
    // sequential address can be issued immediately (1 instr/cycle). Never
    // issued in a redirect cycle since pc+4 is then wrong-path.
    w_fast_req = (r_state == S_WAIT) && imem_resp_valid && hazardFEEnable && !ex_redirect;

    imem_req_valid = !rst && ((r_state == S_REQ) || w_fast_req);
    imem_req_addr  = (r_state == S_WAIT) ? w_pc_plus4 : r_pc;
    w_handshake    = imem_req_valid && imem_req_ready;

    // An instruction reaches IF/ID either straight from memory or from the skid.
    w_deliver      = !ex_redirect && hazardFEEnable &&
                     (((r_state == S_WAIT) && imem_resp_valid) || (r_state == S_HOLD));
    w_deliver_data = (r_state == S_HOLD) ? r_skid : imem_resp_data;

    w_state_next = r_state;
    if (ex_redirect) begin
      case (r_state)
        S_REQ:   w_state_next = w_handshake ? S_DROP : S_REQ;
        S_WAIT:  w_state_next = imem_resp_valid ? S_REQ : S_DROP;
        S_HOLD:  w_state_next = S_REQ;
        default: w_state_next = S_DROP;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem_req_ready) w_state_next = S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (!hazardFEEnable)  w_state_next = S_HOLD;
            else if (w_handshake) w_state_next = S_WAIT;
            else                  w_state_next = S_REQ;
          end
        end
        S_HOLD: begin
          if (hazardFEEnable) w_state_next = S_REQ;
        end
        default: begin
          if (imem_resp_valid) w_state_next = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_REQ;
      r_pc             <= RESET_PC;
      r_skid           <= 32'd0;
      r_if_id_valid    <= 1'b0;
      r_if_id_pc       <= 32'd0;
      r_if_id_pc_plus4 <= 32'd0;
      r_if_id_instr    <= NOP_INSTR;
    end else begin
      r_state <= w_state_next;

      if (ex_redirect) begin
        r_pc <= ex_redirect_pc & ~32'd3;
      end else if (w_deliver) begin
        r_pc <= w_pc_plus4;
      end

      if ((r_state == S_WAIT) && imem_resp_valid && !hazardFEEnable && !ex_redirect) begin
        r_skid <= imem_resp_data;
      end

      // Redirect flushes even when stalled; a bubble keeps the old PC fields.
      if (ex_redirect) begin
        r_if_id_valid <= 1'b0;
        r_if_id_instr <= NOP_INSTR;
      end else if (hazardFEEnable) begin
        if (w_deliver) begin
          r_if_id_valid    <= 1'b1;
          r_if_id_pc       <= r_pc;
          r_if_id_pc_plus4 <= w_pc_plus4;
          r_if_id_instr    <= w_deliver_data;
        end else begin
          r_if_id_valid <= 1'b0;
          r_if_id_instr <= NOP_INSTR;
        end
      end
    end
  end

  assign if_id_valid    = r_if_id_valid;
  assign if_id_pc       = r_if_id_pc;
  assign if_id_pc_plus4 = r_if_id_pc_plus4;
  assign if_id_instr    = r_if_id_instr;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
//   Directed bench for if_stage. A behavioural instruction memory returns the
//   request address as the instruction word with a programmable latency. Each
//   expected IF/ID delivery is queued when the stimulus implies it and popped
//   when IF/ID loads a valid instruction. A second instance checks PC wrap.
// -----------------------------------------------------------------------------
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = 32'd0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        ready = 1'b1;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        id_valid;
  logic [31:0] id_pc, id_pc4, id_instr;

  // Wrap instance signals
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_id_valid;
  logic [31:0] w_id_pc, w_id_pc4, w_id_instr;

  int          n_checks = 0;
  int          n_fail = 0;
  int          mem_lat = 1;
  logic        en_at_edge = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0100), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .hazardFEEnable(en), .ex_redirect(redir),
    .ex_redirect_pc(redir_pc), .imem_req_valid(req_valid), .imem_req_addr(req_addr),
    .imem_req_ready(ready), .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .if_id_valid(id_valid), .if_id_pc(id_pc), .if_id_pc_plus4(id_pc4),
    .if_id_instr(id_instr)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) dut_wrap (
    .clk(clk), .rst(rst), .hazardFEEnable(1'b1), .ex_redirect(1'b0),
    .ex_redirect_pc(32'd0), .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(1'b1), .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .if_id_valid(w_id_valid), .if_id_pc(w_id_pc), .if_id_pc_plus4(w_id_pc4),
    .if_id_instr(w_id_instr)
  );

  // Main memory model: returns addr as data, mem_lat cycles after acceptance.
  logic        pend;
  logic [31:0] pend_addr;
  int          cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= 1'b0;
      pend_addr  <= 32'd0;
      cnt        <= 0;
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          resp_valid <= 1'b1;
          resp_data  <= pend_addr;
          pend       <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (req_valid && ready) begin
        if (mem_lat <= 1) begin
          resp_valid <= 1'b1;
          resp_data  <= req_addr;
        end else begin
          pend      <= 1'b1;
          pend_addr <= req_addr;
          cnt       <= mem_lat - 1;
        end
      end
    end
  end

  // Wrap-instance memory: always ready, 1-cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      w_resp_valid <= 1'b0;
      w_resp_data  <= 32'd0;
    end else begin
      w_resp_valid <= w_req_valid;
      w_resp_data  <= w_req_addr;
    end
  end

  always @(posedge clk) en_at_edge <= en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every IF/ID load of a valid instruction pops one expectation.
  always @(negedge clk) begin
    if (!rst && en_at_edge && id_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc", id_pc, e);
        check("sb_instr", id_instr, e);
        check("sb_pc4", id_pc4, e + 32'd4);
        $display("IF/ID delivered pc=%h instr=%h pc4=%h (expected pc %h)", id_pc, id_instr, id_pc4, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_instr", id_instr, 32'h13);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_pc4", id_pc4, 32'd0);

    // Sequential fetch
    rst = 1'b0;
    #1;
    check("first_req_valid", 32'(req_valid), 32'd1);
    check("first_req_addr", req_addr, 32'h100);
    check("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);
    exp_q.push_back(32'h100);
    tick();                                   // E1
    check("req2_addr", req_addr, 32'h104);
    check("req2_valid", 32'(req_valid), 32'd1);
    check("wrap_second_addr", w_req_addr, 32'h0);
    exp_q.push_back(32'h104);
    tick();                                   // E2
    check("req3_addr", req_addr, 32'h108);
    check("id_pc4_first", id_pc4, 32'h104);
    check("wrap_id_pc", w_id_pc, 32'hFFFF_FFFC);
    check("wrap_id_pc4", w_id_pc4, 32'h0);
    check("wrap_id_instr", w_id_instr, 32'hFFFF_FFFC);
    exp_q.push_back(32'h108);
    tick();                                   // E3: response 0x108 present

    // Stall across the response
    en = 1'b0;
    #1;
    check("stall_no_req", 32'(req_valid), 32'd0);
    tick();                                   // E4: HOLD
    check("hold1_id_pc", id_pc, 32'h104);
    check("hold1_id_valid", 32'(id_valid), 32'd1);
    check("hold1_no_req", 32'(req_valid), 32'd0);
    tick();                                   // E5
    check("hold2_id_pc", id_pc, 32'h104);
    en = 1'b1;
    #1;
    check("hold_release_no_req", 32'(req_valid), 32'd0);
    tick();                                   // E6: skid -> IF/ID
    check("after_hold_req", req_addr, 32'h10C);
    check("after_hold_req_valid", 32'(req_valid), 32'd1);
    exp_q.push_back(32'h10C);
    tick();                                   // E7
    check("bubble_after_hold", 32'(id_valid), 32'd0);
    check("fast_req_110", req_addr, 32'h110);
    mem_lat = 2;
    tick();                                   // E8: 0x110 outstanding

    // Redirect while waiting
    redir = 1'b1;
    redir_pc = 32'h203;
    #1;
    check("redir_wait_no_req", 32'(req_valid), 32'd0);
    tick();                                   // E9: DROP
    redir = 1'b0;
    mem_lat = 1;
    #1;
    check("redir_flush_valid", 32'(id_valid), 32'd0);
    check("redir_flush_instr", id_instr, 32'h13);
    check("drop_no_req", 32'(req_valid), 32'd0);
    tick();                                   // E10: stale response dropped
    check("redir_target_req", req_addr, 32'h200);
    check("redir_target_valid", 32'(req_valid), 32'd1);
    exp_q.push_back(32'h200);
    tick();                                   // E11
    tick();                                   // E12: IF/ID 0x200, resp 0x204
    check("pre_flush_valid", 32'(id_valid), 32'd1);

    // Redirect + response + stall together
    redir = 1'b1;
    redir_pc = 32'h200;
    en = 1'b0;
    #1;
    check("redir_resp_no_req", 32'(req_valid), 32'd0);
    tick();                                   // E13
    redir = 1'b0;
    en = 1'b1;
    #1;
    check("redir_stall_flush", 32'(id_valid), 32'd0);
    check("redir_stall_instr", id_instr, 32'h13);
    check("redir_stall_req", req_addr, 32'h200);
    check("redir_stall_req_valid", 32'(req_valid), 32'd1);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    tick();                                   // E14
    tick();                                   // E15

    // Backpressure then asynchronous reset mid-WAIT
    ready = 1'b0;
    #1;
    check("bp_fast_valid", 32'(req_valid), 32'd1);
    check("bp_fast_addr", req_addr, 32'h208);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", 32'(req_valid), 32'd1);
      check("bp_hold_addr", req_addr, 32'h208);
    end
    ready = 1'b1;
    mem_lat = 2;
    tick();                                   // E19: accepted, WAIT
    #2;
    rst = 1'b1;
    #1;
    check("arst_req_valid", 32'(req_valid), 32'd0);
    check("arst_id_valid", 32'(id_valid), 32'd0);
    check("arst_id_instr", id_instr, 32'h13);
    check("arst_id_pc", id_pc, 32'd0);
    check("arst_id_pc4", id_pc4, 32'd0);
    tick();
    rst = 1'b0;
    mem_lat = 1;
    #1;
    check("post_rst_req", req_addr, 32'h100);
    check("post_rst_req_valid", 32'(req_valid), 32'd1);
    exp_q.push_back(32'h100);
    tick();
    tick();                                   // 0x100 delivered
    en = 1'b0;
    @(negedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
